// File: rtl/dcache_flush_unit.sv
// Flush responder for the write-back dcache: walks every set, writes back
// valid+dirty lines in ascending way order, invalidates the set, then acks.
module dcache_flush_unit #(
   parameter int unsigned NumSets  = 256,
   parameter int unsigned NumWays  = 8,
   parameter int unsigned TagW     = 44,
   parameter int unsigned LineOffW = 4,
   localparam int unsigned IndexW  = $clog2(NumSets),
   localparam int unsigned WayW    = (NumWays > 1) ? $clog2(NumWays) : 1,
   localparam int unsigned PAddrW  = TagW + IndexW + LineOffW
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    flush_req_i,
   output logic                    flush_ack_o,
   output logic                    busy_o,
   output logic                    tag_req_o,
   output logic [IndexW-1:0]       tag_idx_o,
   input  logic                    tag_gnt_i,
   input  logic [NumWays-1:0]      tag_valid_i,
   input  logic [NumWays-1:0]      tag_dirty_i,
   input  logic [NumWays*TagW-1:0] tag_rdata_i,
   output logic                    wb_valid_o,
   input  logic                    wb_ready_i,
   output logic [PAddrW-1:0]       wb_addr_o,
   output logic [WayW-1:0]         wb_way_o,
   output logic                    inv_req_o,
   output logic [IndexW-1:0]       inv_idx_o,
   output logic [NumWays-1:0]      inv_way_mask_o,
   input  logic                    inv_gnt_i
);

   typedef enum logic [2:0] {
      IDLE,
      READ_TAG,
      CHECK,
      WRITEBACK,
      INVALIDATE,
      DONE
   } state_t;

   state_t              state_q;
   logic [IndexW-1:0]   set_q;
   logic [NumWays-1:0]  pend_q;
   logic [TagW-1:0]     tags_q [NumWays];
   logic                ack_q;
   logic                busy_q;
   logic                tag_req_q;
   logic                wb_valid_q;
   logic                inv_req_q;

   logic [WayW-1:0]     wb_way;
   logic                wb_found;
   logic [NumWays-1:0]  pend_next;
   logic [NumWays-1:0]  dirty_lines;

   assign dirty_lines = tag_valid_i & tag_dirty_i;
   // Clearing the lowest set bit retires the way currently being written back
   assign pend_next   = pend_q & (pend_q - NumWays'(1));

   // Priority-encode the lowest pending way so writebacks go out in ascending order
   always_comb begin
      wb_way   = '0;
      wb_found = 1'b0;
      for (int unsigned w = 0; w < NumWays; w++) begin
         if (pend_q[w] && !wb_found) begin
            wb_way   = WayW'(w);
            wb_found = 1'b1;
         end
      end
   end

   // Flush walk FSM; every output flag is registered alongside the state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         set_q      <= '0;
         pend_q     <= '0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         tag_req_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         inv_req_q  <= 1'b0;
         for (int unsigned w = 0; w < NumWays; w++) begin
            tags_q[w] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_req_i) begin
                  state_q   <= READ_TAG;
                  set_q     <= '0;
                  busy_q    <= 1'b1;
                  tag_req_q <= 1'b1;
               end
            end
            READ_TAG: begin
               if (tag_gnt_i) begin
                  state_q   <= CHECK;
                  tag_req_q <= 1'b0;
               end
            end
            CHECK: begin
               pend_q <= dirty_lines;
               for (int unsigned w = 0; w < NumWays; w++) begin
                  tags_q[w] <= tag_rdata_i[w*TagW +: TagW];
               end
               if (dirty_lines != '0) begin
                  state_q    <= WRITEBACK;
                  wb_valid_q <= 1'b1;
               end else begin
                  state_q   <= INVALIDATE;
                  inv_req_q <= 1'b1;
               end
            end
            WRITEBACK: begin
               if (wb_ready_i) begin
                  pend_q <= pend_next;
                  if (pend_next == '0) begin
                     state_q    <= INVALIDATE;
                     wb_valid_q <= 1'b0;
                     inv_req_q  <= 1'b1;
                  end
               end
            end
            INVALIDATE: begin
               if (inv_gnt_i) begin
                  inv_req_q <= 1'b0;
                  if (set_q == IndexW'(NumSets - 1)) begin
                     state_q <= DONE;
                     ack_q   <= 1'b1;
                  end else begin
                     state_q   <= READ_TAG;
                     set_q     <= set_q + IndexW'(1);
                     tag_req_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               ack_q      <= 1'b0;
               busy_q     <= 1'b0;
               tag_req_q  <= 1'b0;
               wb_valid_q <= 1'b0;
               inv_req_q  <= 1'b0;
            end
         endcase
      end
   end

   assign flush_ack_o    = ack_q;
   assign busy_o         = busy_q;
   assign tag_req_o      = tag_req_q;
   assign tag_idx_o      = set_q;
   assign wb_valid_o     = wb_valid_q;
   assign wb_addr_o      = wb_valid_q ? {tags_q[wb_way], set_q, {LineOffW{1'b0}}} : '0;
   assign wb_way_o       = wb_valid_q ? wb_way : '0;
   assign inv_req_o      = inv_req_q;
   assign inv_idx_o      = set_q;
   assign inv_way_mask_o = {NumWays{inv_req_q}};

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Self-checking bench for dcache_flush_unit: the bench plays tag array,
// writeback path and invalidate port, and compares the observed event stream
// and ack timing against a set/way walk model.
module tb_dcache_flush_unit;

   localparam int NS = 4;
   localparam int NW = 2;
   localparam int TW = 8;
   localparam int LO = 4;
   localparam int IW = 2;
   localparam int PW = TW + IW + LO;
   localparam int WW = 1;

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic              flush_req_i = 1'b0;
   logic              flush_ack_o;
   logic              busy_o;
   logic              tag_req_o;
   logic [IW-1:0]     tag_idx_o;
   logic              tag_gnt_i = 1'b0;
   logic [NW-1:0]     tag_valid_i = '0;
   logic [NW-1:0]     tag_dirty_i = '0;
   logic [NW*TW-1:0]  tag_rdata_i = '0;
   logic              wb_valid_o;
   logic              wb_ready_i = 1'b0;
   logic [PW-1:0]     wb_addr_o;
   logic [WW-1:0]     wb_way_o;
   logic              inv_req_o;
   logic [IW-1:0]     inv_idx_o;
   logic [NW-1:0]     inv_way_mask_o;
   logic              inv_gnt_i = 1'b0;

   always #5 clk = ~clk;

   dcache_flush_unit #(
      .NumSets (NS),
      .NumWays (NW),
      .TagW    (TW),
      .LineOffW(LO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_req_i   (flush_req_i),
      .flush_ack_o   (flush_ack_o),
      .busy_o        (busy_o),
      .tag_req_o     (tag_req_o),
      .tag_idx_o     (tag_idx_o),
      .tag_gnt_i     (tag_gnt_i),
      .tag_valid_i   (tag_valid_i),
      .tag_dirty_i   (tag_dirty_i),
      .tag_rdata_i   (tag_rdata_i),
      .wb_valid_o    (wb_valid_o),
      .wb_ready_i    (wb_ready_i),
      .wb_addr_o     (wb_addr_o),
      .wb_way_o      (wb_way_o),
      .inv_req_o     (inv_req_o),
      .inv_idx_o     (inv_idx_o),
      .inv_way_mask_o(inv_way_mask_o),
      .inv_gnt_i     (inv_gnt_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // cache contents seen by the flush
   logic [NW-1:0] mem_valid [NS];
   logic [NW-1:0] mem_dirty [NS];
   logic [TW-1:0] mem_tag   [NS][NW];

   // stall configuration
   bit rand_mode     = 1'b0;
   int tag_stall_set = -1;
   int tag_stall_left = 0;
   int wb_stall_left = 0;
   bit stop_on_wb    = 1'b0;

   // observations
   int   obs_ack_cycle;
   int   obs_ack_count;
   int   obs_unstable;
   int   obs_stalls;
   int   obs_stopped;
   logic obs_busy_after;
   int   obs_ev[$];
   int   obs_wb_cycle[$];
   int   exp_ev[$];
   int   exp_nwb;

   // Model: sets ascending; within a set dirty ways ascending, then invalidate
   function automatic void build_expected();
      exp_ev.delete();
      exp_nwb = 0;
      for (int s = 0; s < NS; s++) begin
         for (int w = 0; w < NW; w++) begin
            if (mem_valid[s][w] && mem_dirty[s][w]) begin
               int addr;
               addr = int'(mem_tag[s][w]) * (NS * (1 << LO)) + s * (1 << LO);
               exp_ev.push_back(32'h0100_0000 + w * 32'h1_0000 + addr);
               exp_nwb++;
            end
         end
         exp_ev.push_back(32'h0200_0000 + s);
      end
   endfunction

   function automatic int log_diffs();
      int d;
      d = 0;
      if (obs_ev.size() != exp_ev.size()) d++;
      for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++)
         if (obs_ev[i] != exp_ev[i]) d++;
      return d;
   endfunction

   function automatic void fill_random(input bit dirty_ok);
      for (int s = 0; s < NS; s++) begin
         mem_valid[s] = NW'($urandom);
         mem_dirty[s] = dirty_ok ? NW'($urandom) : '0;
         for (int w = 0; w < NW; w++) mem_tag[s][w] = TW'($urandom);
      end
   endfunction

   // Drives one flush from request to three cycles past ack, acting as the
   // tag array / writeback / invalidate responders and logging events.
   task automatic run_flush(input int max_cycles);
      int            c;
      int            post;
      bit            rd_pend;
      int            rd_idx;
      bit            prev_tstall;
      bit            prev_wstall;
      logic [IW-1:0] prev_tidx;
      logic [PW-1:0] prev_addr;
      logic [WW-1:0] prev_way;
      obs_ack_cycle = -1;
      obs_ack_count = 0;
      obs_unstable  = 0;
      obs_stalls    = 0;
      obs_stopped   = 0;
      obs_ev.delete();
      obs_wb_cycle.delete();
      rd_pend = 1'b0; rd_idx = 0; prev_tstall = 1'b0; prev_wstall = 1'b0;
      prev_tidx = '0; prev_addr = '0; prev_way = '0;
      post = -1;
      @(negedge clk);
      c = 0;
      flush_req_i = 1'b1;
      tag_gnt_i = 1'b1; wb_ready_i = 1'b1; inv_gnt_i = 1'b1;
      while (c < max_cycles) begin
         @(negedge clk);
         c++;
         if (prev_tstall && (!tag_req_o || tag_idx_o != prev_tidx)) obs_unstable++;
         if (prev_wstall && (!wb_valid_o || wb_addr_o != prev_addr || wb_way_o != prev_way))
            obs_unstable++;
         if (rd_pend) begin
            tag_valid_i = mem_valid[rd_idx];
            tag_dirty_i = mem_dirty[rd_idx];
            for (int w = 0; w < NW; w++) tag_rdata_i[w*TW +: TW] = mem_tag[rd_idx][w];
         end else begin
            tag_valid_i = NW'($urandom);
            tag_dirty_i = NW'($urandom);
            tag_rdata_i = (NW*TW)'($urandom);
         end
         if (flush_ack_o) begin
            obs_ack_count++;
            if (obs_ack_cycle < 0) begin
               obs_ack_cycle = c;
               post = c + 3;
            end
            flush_req_i = 1'b0;
         end
         if (stop_on_wb && wb_valid_o) begin
            obs_stopped = 1;
            wb_ready_i = 1'b0;
            break;
         end
         // tag read grant
         if (rand_mode) tag_gnt_i = ($urandom_range(0, 3) != 0);
         else if (tag_req_o && int'(tag_idx_o) == tag_stall_set && tag_stall_left > 0) begin
            tag_gnt_i = 1'b0;
            tag_stall_left--;
         end else tag_gnt_i = 1'b1;
         if (tag_req_o && !tag_gnt_i) obs_stalls++;
         rd_pend = tag_req_o && tag_gnt_i;
         rd_idx = int'(tag_idx_o);
         prev_tstall = tag_req_o && !tag_gnt_i;
         prev_tidx = tag_idx_o;
         // writeback ready
         if (rand_mode) wb_ready_i = ($urandom_range(0, 2) != 0);
         else if (wb_valid_o && wb_stall_left > 0) begin
            wb_ready_i = 1'b0;
            wb_stall_left--;
         end else wb_ready_i = 1'b1;
         if (wb_valid_o && !wb_ready_i) obs_stalls++;
         if (wb_valid_o && wb_ready_i) begin
            obs_ev.push_back(32'h0100_0000 + int'(wb_way_o) * 32'h1_0000 + int'(wb_addr_o));
            obs_wb_cycle.push_back(c);
         end
         prev_wstall = wb_valid_o && !wb_ready_i;
         prev_addr = wb_addr_o;
         prev_way = wb_way_o;
         // invalidate grant
         if (rand_mode) inv_gnt_i = ($urandom_range(0, 2) != 0);
         else inv_gnt_i = 1'b1;
         if (inv_req_o && !inv_gnt_i) obs_stalls++;
         if (inv_req_o && inv_gnt_i) begin
            obs_ev.push_back(32'h0200_0000 + int'(inv_idx_o));
            if (inv_way_mask_o != '1) obs_unstable++;
            mem_valid[int'(inv_idx_o)] = '0;
         end
         if (c == post) break;
      end
      obs_busy_after = busy_o;
      flush_req_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      #1;
      n_checks++;
      if ({flush_ack_o, busy_o, tag_req_o, tag_idx_o, wb_valid_o, wb_addr_o, wb_way_o,
           inv_req_o, inv_idx_o, inv_way_mask_o} !== '0)
         begin n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0"); end
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
   endtask

   task automatic test_clean();
      fill_random(1'b0);
      build_expected();
      rand_mode = 1'b0; tag_stall_set = -1; wb_stall_left = 0;
      run_flush(200);
      n_checks++;
      if (obs_ack_cycle != 13) begin n_fail++; $display("FAIL clean_ack_cycle: got %0d required 13", obs_ack_cycle); end
      n_checks++;
      if (obs_ack_count != 1) begin n_fail++; $display("FAIL clean_ack_count: got %0d required 1", obs_ack_count); end
      n_checks++;
      if (obs_wb_cycle.size() != 0) begin n_fail++; $display("FAIL clean_no_wb: got %0d writebacks required 0", obs_wb_cycle.size()); end
      n_checks++;
      if (log_diffs() != 0) begin n_fail++; $display("FAIL clean_events: got %0d differing entries required 0", log_diffs()); end
      n_checks++;
      if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL clean_busy_after: got %b required 0", obs_busy_after); end
   endtask

   task automatic test_wb_stall();
      fill_random(1'b0);
      mem_valid[2][1] = 1'b1; mem_dirty[2][1] = 1'b1; mem_tag[2][1] = 8'h05;
      build_expected();
      rand_mode = 1'b0; tag_stall_set = -1; wb_stall_left = 5;
      run_flush(200);
      n_checks++;
      if (obs_ack_cycle != 19) begin n_fail++; $display("FAIL wbstall_ack_cycle: got %0d required 19", obs_ack_cycle); end
      n_checks++;
      if (obs_ev.size() < 1 || obs_ev[2] != 32'h0101_0160)
         begin n_fail++; $display("FAIL wbstall_addr: got event list size %0d, required way1 addr 0x160 after two invalidates", obs_ev.size()); end
      n_checks++;
      if (obs_unstable != 0) begin n_fail++; $display("FAIL wbstall_stable: got %0d instabilities required 0", obs_unstable); end
      n_checks++;
      if (log_diffs() != 0) begin n_fail++; $display("FAIL wbstall_events: got %0d differing entries required 0", log_diffs()); end
   endtask

   task automatic test_back_to_back();
      fill_random(1'b0);
      mem_valid[0] = 2'b11; mem_dirty[0] = 2'b11;
      mem_tag[0][0] = 8'h0A; mem_tag[0][1] = 8'h0B;
      build_expected();
      rand_mode = 1'b0; tag_stall_set = -1; wb_stall_left = 0;
      run_flush(200);
      n_checks++;
      if (obs_ev.size() < 2 || obs_ev[0] != 32'h0100_0280 || obs_ev[1] != 32'h0101_02C0)
         begin n_fail++; $display("FAIL b2b_order: got %0d events, required 0x280/way0 then 0x2C0/way1", obs_ev.size()); end
      n_checks++;
      if (obs_wb_cycle.size() != 2 || obs_wb_cycle[1] != obs_wb_cycle[0] + 1)
         begin n_fail++; $display("FAIL b2b_consecutive: got %0d writebacks, required 2 in consecutive cycles", obs_wb_cycle.size()); end
      n_checks++;
      if (obs_ack_cycle != 15) begin n_fail++; $display("FAIL b2b_ack_cycle: got %0d required 15", obs_ack_cycle); end
   endtask

   task automatic test_tag_stall();
      fill_random(1'b0);
      build_expected();
      rand_mode = 1'b0; tag_stall_set = 1; tag_stall_left = 3; wb_stall_left = 0;
      run_flush(200);
      n_checks++;
      if (obs_ack_cycle != 16) begin n_fail++; $display("FAIL tagstall_ack_cycle: got %0d required 16", obs_ack_cycle); end
      n_checks++;
      if (obs_stalls != 3) begin n_fail++; $display("FAIL tagstall_count: got %0d stalled cycles required 3", obs_stalls); end
      n_checks++;
      if (obs_unstable != 0) begin n_fail++; $display("FAIL tagstall_stable: got %0d instabilities required 0", obs_unstable); end
      tag_stall_set = -1;
   endtask

   task automatic test_reset_mid_flush();
      fill_random(1'b0);
      mem_valid[0][0] = 1'b1; mem_dirty[0][0] = 1'b1; mem_tag[0][0] = 8'h3C;
      rand_mode = 1'b0; tag_stall_set = -1; wb_stall_left = 0;
      stop_on_wb = 1'b1;
      run_flush(100);
      stop_on_wb = 1'b0;
      n_checks++;
      if (obs_stopped != 1) begin n_fail++; $display("FAIL midrst_reach_wb: got %0d required 1", obs_stopped); end
      rst_i = 1'b1;
      #1;
      n_checks++;
      if ({flush_ack_o, busy_o, tag_req_o, wb_valid_o, wb_addr_o, wb_way_o, inv_req_o,
           inv_way_mask_o} !== '0)
         begin n_fail++; $display("FAIL midrst_outputs: got nonzero outputs, required all 0"); end
      @(negedge clk);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy_o !== 1'b0 || flush_ack_o !== 1'b0)
         begin n_fail++; $display("FAIL midrst_idle: got busy %b ack %b required 0 0", busy_o, flush_ack_o); end
      build_expected();
      run_flush(200);
      n_checks++;
      if (log_diffs() != 0) begin n_fail++; $display("FAIL midrst_events: got %0d differing entries required 0", log_diffs()); end
      n_checks++;
      if (obs_ack_count != 1 || obs_ack_cycle != 14)
         begin n_fail++; $display("FAIL midrst_ack: got %0d acks at cycle %0d required 1 at 14", obs_ack_count, obs_ack_cycle); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         fill_random(1'b1);
         build_expected();
         rand_mode = 1'b1;
         run_flush(600);
         n_checks++;
         if (log_diffs() != 0) begin n_fail++; $display("FAIL rand_events[%0d]: got %0d differing entries required 0", it, log_diffs()); end
         n_checks++;
         if (obs_ack_count != 1) begin n_fail++; $display("FAIL rand_ack_count[%0d]: got %0d required 1", it, obs_ack_count); end
         n_checks++;
         if (obs_ack_cycle != 1 + 3 * NS + exp_nwb + obs_stalls)
            begin n_fail++; $display("FAIL rand_ack_cycle[%0d]: got %0d required %0d", it, obs_ack_cycle, 1 + 3 * NS + exp_nwb + obs_stalls); end
         n_checks++;
         if (obs_unstable != 0) begin n_fail++; $display("FAIL rand_stable[%0d]: got %0d instabilities required 0", it, obs_unstable); end
         n_checks++;
         if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand_busy_after[%0d]: got %b required 0", it, obs_busy_after); end
      end
      rand_mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_clean();
      test_wb_stall();
      test_back_to_back();
      test_tag_stall();
      test_reset_mid_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
